// File: rtl/fifo_ctrl_6x8_pkg.sv
// Shared sizing and flag payload types for the 6x8 FIFO memory, its
// controller and the bench.
package fifo_ctrl_6x8_pkg;

  localparam int unsigned FIFO_DEPTH  = 6;
  localparam int unsigned FIFO_PTR_W  = 6;
  localparam int unsigned FIFO_DATA_W = 8;
  localparam int unsigned FIFO_CNT_W  = 4;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

  localparam fifo_flags_t FIFO_FLAGS_RST = '{
    full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1
  };

endpackage

// File: rtl/fifo_ctrl_6x8_ptr_wrap_inc.sv
// Registered memory pointer that advances on enable and wraps from
// DEPTH-1 back to 0; synchronous active-high reset.
module ptr_wrap_inc
  import fifo_ctrl_6x8_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH,
  parameter int unsigned PTR_W = FIFO_PTR_W
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  output logic [PTR_W-1:0] ptr_o
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl_6x8.sv
// Push/pop to memory-strobe controller for the 6x8 FIFO: pointers,
// occupancy, threshold flags and sticky overflow/underflow errors.
module fifo_ctrl_6x8
  import fifo_ctrl_6x8_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH,
  parameter int unsigned PTR_W = FIFO_PTR_W,
  parameter int unsigned CNT_W = FIFO_CNT_W
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [CNT_W-1:0] af_th_i,
  input  logic [CNT_W-1:0] ae_th_i,
  output logic             write_c_o,
  output logic             read_c_o,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic             overflow_err_o,
  output logic             underflow_err_o
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  fifo_flags_t      flags_q;
  fifo_flags_t      flags_d;
  fifo_err_t        err_q;
  fifo_err_t        err_d;
  logic             write_c;
  logic             read_c;

  // Full blocks push even alongside pop so the entry at rd_ptr is never
  // overwritten; empty blocks pop even alongside push (no fall-through).
  assign write_c = push_i & ~flags_q.full  & ~reset_i;
  assign read_c  = pop_i  & ~flags_q.empty & ~reset_i;

  always_comb begin
    count_d = count_q;
    unique case ({write_c, read_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Flags track the post-edge count and the thresholds presented this cycle.
  always_comb begin
    flags_d              = FIFO_FLAGS_RST;
    flags_d.full         = (count_d == CNT_FULL);
    flags_d.empty        = (count_d == '0);
    flags_d.almost_full  = (count_d >= af_th_i);
    flags_d.almost_empty = (count_d <= ae_th_i);
  end

  always_comb begin
    err_d           = err_q;
    err_d.overflow  = err_q.overflow  | (push_i & flags_q.full);
    err_d.underflow = err_q.underflow | (pop_i  & flags_q.empty);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
      flags_q <= FIFO_FLAGS_RST;
      err_q   <= '0;
    end else begin
      count_q <= count_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  ptr_wrap_inc #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_wr_ptr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (write_c),
    .ptr_o   (wr_ptr_o)
  );

  ptr_wrap_inc #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_rd_ptr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (read_c),
    .ptr_o   (rd_ptr_o)
  );

  assign write_c_o       = write_c;
  assign read_c_o        = read_c;
  assign count_o         = count_q;
  assign full_o          = flags_q.full;
  assign empty_o         = flags_q.empty;
  assign almost_full_o   = flags_q.almost_full;
  assign almost_empty_o  = flags_q.almost_empty;
  assign overflow_err_o  = err_q.overflow;
  assign underflow_err_o = err_q.underflow;

endmodule

// File: tb/tb_fifo_ctrl_6x8.sv
// Bench for fifo_ctrl_6x8: directed plan plus random push/pop traffic
// against a queue-based reference, with a bench-side 6x8 memory.
module tb_fifo_ctrl_6x8;
  import fifo_ctrl_6x8_pkg::*;

  logic                  clk_i = 1'b0;
  logic                  reset_i = 1'b1;
  logic                  push_i = 1'b0;
  logic                  pop_i = 1'b0;
  logic [FIFO_CNT_W-1:0] af_th_i = 4'd5;
  logic [FIFO_CNT_W-1:0] ae_th_i = 4'd1;
  logic                  write_c_o;
  logic                  read_c_o;
  logic [FIFO_PTR_W-1:0] wr_ptr_o;
  logic [FIFO_PTR_W-1:0] rd_ptr_o;
  logic [FIFO_CNT_W-1:0] count_o;
  logic                  full_o;
  logic                  empty_o;
  logic                  almost_full_o;
  logic                  almost_empty_o;
  logic                  overflow_err_o;
  logic                  underflow_err_o;

  fifo_ctrl_6x8 dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .push_i          (push_i),
    .pop_i           (pop_i),
    .af_th_i         (af_th_i),
    .ae_th_i         (ae_th_i),
    .write_c_o       (write_c_o),
    .read_c_o        (read_c_o),
    .wr_ptr_o        (wr_ptr_o),
    .rd_ptr_o        (rd_ptr_o),
    .count_o         (count_o),
    .full_o          (full_o),
    .empty_o         (empty_o),
    .almost_full_o   (almost_full_o),
    .almost_empty_o  (almost_empty_o),
    .overflow_err_o  (overflow_err_o),
    .underflow_err_o (underflow_err_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Reference state: FIFO contents, accept totals, sticky errors, flags.
  logic [FIFO_DATA_W-1:0] model_q[$];
  int unsigned            wr_total = 0;
  int unsigned            rd_total = 0;
  bit                     m_ovf = 1'b0;
  bit                     m_unf = 1'b0;
  bit                     m_af  = 1'b0;
  bit                     m_ae  = 1'b1;
  logic [FIFO_DATA_W-1:0] mem [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit push, input bit pop, input bit rst, input logic [7:0] din);
    logic [FIFO_DATA_W-1:0] dout;
    logic [FIFO_DATA_W-1:0] exp_d;
    bit e_w;
    bit e_r;
    bit was_full;
    bit was_empty;
    dout = '0;
    @(negedge clk_i);
    push_i  = push;
    pop_i   = pop;
    reset_i = rst;
    #1;
    was_full  = (model_q.size() == FIFO_DEPTH);
    was_empty = (model_q.size() == 0);
    e_w = push && !rst && !was_full;
    e_r = pop && !rst && !was_empty;
    chk("write", 32'(write_c_o), 32'(e_w));
    chk("read", 32'(read_c_o), 32'(e_r));
    if (read_c_o === 1'b1) dout = mem[rd_ptr_o];
    if (write_c_o === 1'b1) mem[wr_ptr_o] = din;
    @(posedge clk_i);
    #1;
    if (rst) begin
      model_q.delete();
      wr_total = 0;
      rd_total = 0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_af  = 1'b0;
      m_ae  = 1'b1;
    end else begin
      if (e_r) begin
        exp_d = model_q.pop_front();
        chk("data_out", 32'(dout), 32'(exp_d));
        rd_total++;
      end
      if (e_w) begin
        model_q.push_back(din);
        wr_total++;
      end
      if (push && was_full) m_ovf = 1'b1;
      if (pop && was_empty) m_unf = 1'b1;
      m_af = (model_q.size() >= int'(af_th_i));
      m_ae = (model_q.size() <= int'(ae_th_i));
    end
    chk("wr_ptr", 32'(wr_ptr_o), wr_total % FIFO_DEPTH);
    chk("rd_ptr", 32'(rd_ptr_o), rd_total % FIFO_DEPTH);
    chk("count", 32'(count_o), model_q.size());
    chk("full", 32'(full_o), 32'(model_q.size() == FIFO_DEPTH));
    chk("empty", 32'(empty_o), 32'(model_q.size() == 0));
    chk("almost_full", 32'(almost_full_o), 32'(m_af));
    chk("almost_empty", 32'(almost_empty_o), 32'(m_ae));
    chk("overflow_err", 32'(overflow_err_o), 32'(m_ovf));
    chk("underflow_err", 32'(underflow_err_o), 32'(m_unf));
  endtask

  initial begin
    logic [7:0] d;
    bit         p;
    bit         q;
    bit         r;

    // Reset then idle.
    step(1'b0, 1'b0, 1'b1, 8'h00);
    repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("idle_empty", 32'(empty_o), 32'd1);
    chk("idle_ae", 32'(almost_empty_o), 32'd1);

    // Fill with 0x11..0x66, then push into full.
    for (int i = 1; i <= 6; i++) begin
      d = 8'(i * 17);
      step(1'b1, 1'b0, 1'b0, d);
    end
    chk("fill_full", 32'(full_o), 32'd1);
    chk("fill_wrptr", 32'(wr_ptr_o), 32'd0);
    step(1'b1, 1'b0, 1'b0, 8'hEE);
    chk("fill_ovf", 32'(overflow_err_o), 32'd1);

    // Drain in order, then pop from empty.
    repeat (6) step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("drain_empty", 32'(empty_o), 32'd1);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("drain_unf", 32'(underflow_err_o), 32'd1);

    // Steady occupancy of 3 with simultaneous push and pop.
    step(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'(8'hA0 + i));
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 8'(8'hB0 + i));
    chk("steady_count", 32'(count_o), 32'd3);

    // Push+pop while full, then push+pop while empty.
    step(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 8'(8'hC0 + i));
    step(1'b1, 1'b1, 1'b0, 8'hCF);
    chk("full_both_count", 32'(count_o), 32'd5);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'hD1);
    chk("empty_both_count", 32'(count_o), 32'd1);
    chk("empty_both_unf", 32'(underflow_err_o), 32'd1);

    // Reset alongside push from count 4.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'(8'hE0 + i));
    step(1'b1, 1'b0, 1'b1, 8'hEF);
    chk("rst_push_count", 32'(count_o), 32'd0);

    // Random traffic with moving thresholds and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        af_th_i = 4'($urandom_range(0, 15));
        ae_th_i = 4'($urandom_range(0, 15));
      end
      p = ($urandom_range(0, 99) < ((i / 300) % 2 == 0 ? 65 : 35));
      q = ($urandom_range(0, 99) < ((i / 300) % 2 == 0 ? 35 : 65));
      r = ($urandom_range(0, 199) == 0);
      step(p, q, r, 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
